// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: control, key-load and round-key read signals of aes_key_sched (zeroize only with AES_KEY_SCHED_ZEROIZE_EN)
interface aes_key_sched_if;
  logic        start;
  logic [1:0]  key_len;
  logic [31:0] key_word;
  logic        key_valid;
  logic [3:0]  rd_round;
  logic [1:0]  rd_word;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  logic        zeroize;
  modport master (output start, key_len, key_word, key_valid, rd_round, rd_word, zeroize,
                  input rd_data, busy, done, err);
  modport slave (input start, key_len, key_word, key_valid, rd_round, rd_word, zeroize,
                 output rd_data, busy, done, err);
`else
  modport master (output start, key_len, key_word, key_valid, rd_round, rd_word,
                  input rd_data, busy, done, err);
  modport slave (input start, key_len, key_word, key_valid, rd_round, rd_word,
                 output rd_data, busy, done, err);
`endif
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched: AES-128/192/256 key expansion, one word per cycle, random-access round-key reads; optional zeroize via AES_KEY_SCHED_ZEROIZE_EN
module aes_key_sched #(
  parameter int MAX_NK = 8
) (
  input logic clk,
  input logic reset,
  aes_key_sched_if.slave bus
);
  localparam int NW = 4 * (MAX_NK + 7);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  rc_q, rc_d;
  logic [3:0]  nk_q, nk_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [3:0]  nk_sel;
  logic        bad, last_key, last_w;
  logic [5:0]  tot, idx;
  logic [31:0] prev, temp, w_new;
  logic [7:0]  xt;
  assign nk_sel   = bus.key_len == 2'd0 ? 4'd4 : bus.key_len == 2'd1 ? 4'd6 : 4'd8;
  assign bad      = bus.key_len == 2'd3 || int'(nk_sel) > MAX_NK;
  assign tot      = {nk_q, 2'b00} + 6'd28;
  assign idx      = {bus.rd_round, bus.rd_word};
  assign last_key = cnt_q == 6'(nk_q) - 6'd1;
  assign last_w   = cnt_q == tot - 6'd1;
  assign xt       = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
  // k_q tracks i mod Nk and rc_q tracks Rcon[i/Nk], avoiding a divider
  assign prev     = w_q[cnt_q - 6'd1];
  assign temp     = k_q == 3'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rc_q, 24'h0} :
                    (nk_q == 4'd8 && k_q == 3'd4) ? sub_word(prev) : prev;
  assign w_new    = w_q[cnt_q - 6'(nk_q)] ^ temp;
  assign rd_d     = idx < tot ? w_q[idx] : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rc_d    = rc_q;
    nk_d    = nk_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    w_d     = w_q;
    if (bus.start) begin
      cnt_d   = '0;
      k_d     = '0;
      done_d  = 1'b0;
      err_d   = bad;
      busy_d  = !bad;
      state_d = bad ? IDLE : LOAD;
      nk_d    = bad ? nk_q : nk_sel;
    end else if (state_q == LOAD && bus.key_valid) begin
      w_d[cnt_q] = bus.key_word;
      cnt_d      = last_key ? 6'(nk_q) : cnt_q + 6'd1;
      rc_d       = 8'h01;
      state_d    = last_key ? EXPAND : LOAD;
    end else if (state_q == EXPAND) begin
      w_d[cnt_q] = w_new;
      cnt_d      = cnt_q + 6'd1;
      k_d        = 4'(k_q) == nk_q - 4'd1 ? 3'd0 : k_q + 3'd1;
      rc_d       = k_q == 3'd0 ? xt : rc_q;
      done_d     = last_w;
      busy_d     = !last_w;
      state_d    = last_w ? DONE : EXPAND;
    end
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    if (bus.zeroize) begin
      w_d     = '{default: '0};
      state_d = IDLE;
      cnt_d   = '0;
      k_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      rc_q    <= 8'h01;
      nk_q    <= 4'd4;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rc_q    <= rc_d;
      nk_q    <= nk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      w_q     <= w_d;
    end
  end
  assign bus.rd_data = rd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: FIPS-197 key-expansion vectors; round-key reads are scoreboarded and checked by a monitor
module tb_aes_key_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  aes_key_sched_if bus();
  aes_key_sched_if bus4();
  aes_key_sched #(.MAX_NK(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  aes_key_sched #(.MAX_NK(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  typedef struct {logic [31:0] exp; string nm;} rd_t;
  rd_t sbq[$];
  rd_t e;
  int checks = 0;
  int failures = 0;
  logic rd_req = 1'b0;
  logic req_q = 1'b0;
  logic [31:0] k128 [8];
  logic [31:0] k192 [8];
  logic [31:0] k256 [8];
  always @(posedge clk) req_q <= rd_req;
  always @(negedge clk) begin
    if (req_q) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%h", bus.rd_data);
      end else begin
        e = sbq.pop_front();
        if (bus.rd_data !== e.exp) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", e.nm, bus.rd_data, e.exp);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int r, input int w, input logic [31:0] x, input string nm);
    bus.rd_round = 4'(r);
    bus.rd_word  = 2'(w);
    rd_req = 1'b1;
    sbq.push_back('{x, nm});
    cyc;
    rd_req = 1'b0;
  endtask
  task automatic load(input int len, input logic [31:0] k [8], input int nk, input int gap, input logic junk);
    bus.start = 1'b1;
    bus.key_len = 2'(len);
    bus.key_valid = junk;
    bus.key_word = 32'hdeadbeef;
    cyc;
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < nk; i++) begin
      repeat (gap) cyc;
      bus.key_valid = 1'b1;
      bus.key_word = k[i];
      cyc;
      bus.key_valid = 1'b0;
    end
  endtask
  task automatic wait_done(input string nm, input int exp_n);
    int n = 0;
    chk({nm, "_busy_expand"}, {31'd0, bus.busy}, 32'd1);
    while (!bus.done && n < 200) begin
      cyc;
      n++;
    end
    chk({nm, "_cycles"}, 32'(n), 32'(exp_n));
    chk({nm, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    k128 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
    k192 = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5, 32'h62f8ead2, 32'h522c6b7b, 0, 0};
    k256 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
             32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    {bus.start, bus.key_len, bus.key_word, bus.key_valid, bus.rd_round, bus.rd_word} = '0;
    {bus4.start, bus4.key_len, bus4.key_word, bus4.key_valid, bus4.rd_round, bus4.rd_word} = '0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    bus.zeroize = 1'b0;
    bus4.zeroize = 1'b0;
`endif
    repeat (3) cyc;
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'h0);
    chk("rst_flags4", {29'd0, bus4.busy, bus4.done, bus4.err}, 32'h0);
    reset = 1'b1;
    cyc;
    load(0, k128, 4, 0, 1'b0);
    wait_done("aes128", 40);
    rd(0, 0, 32'h2b7e1516, "aes128_w0");
    rd(1, 0, 32'ha0fafe17, "aes128_w4");
    rd(1, 1, 32'h88542cb1, "aes128_w5");
    rd(10, 3, 32'hb6630ca6, "aes128_w43");
    load(1, k192, 6, 0, 1'b0);
    wait_done("aes192", 46);
    rd(1, 1, 32'h522c6b7b, "aes192_w5");
    rd(1, 2, 32'hfe0c91f7, "aes192_w6");
    rd(12, 3, 32'h01002202, "aes192_w51");
    load(2, k256, 8, 0, 1'b0);
    wait_done("aes256", 52);
    rd(1, 3, 32'h0914dff4, "aes256_w7");
    rd(2, 0, 32'h9ba35411, "aes256_w8");
    rd(14, 3, 32'h706c631e, "aes256_w59");
    load(0, k128, 4, 2, 1'b1);
    wait_done("aes128_gaps", 40);
    rd(0, 0, 32'h2b7e1516, "gaps_w0");
    rd(1, 0, 32'ha0fafe17, "gaps_w4");
    rd(10, 3, 32'hb6630ca6, "gaps_w43");
    load(2, k256, 8, 0, 1'b0);
    repeat (10) cyc;
    chk("mid_expand_done", {31'd0, bus.done}, 32'd0);
    load(0, k128, 4, 0, 1'b0);
    wait_done("restart128", 40);
    rd(1, 0, 32'ha0fafe17, "restart_w4");
    rd(10, 3, 32'hb6630ca6, "restart_w43");
    for (int r = 11; r < 16; r++) begin
      rd(r, 0, 32'h0, "beyond_t_w0");
      rd(r, 3, 32'h0, "beyond_t_w3");
    end
    bus.start = 1'b1;
    bus.key_len = 2'd3;
    cyc;
    bus.start = 1'b0;
    chk("illegal_len3_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'h1);
    rd(1, 0, 32'ha0fafe17, "illegal_keeps_w4");
    bus4.start = 1'b1;
    bus4.key_len = 2'd2;
    cyc;
    bus4.start = 1'b0;
    chk("illegal_nk_flags", {29'd0, bus4.busy, bus4.done, bus4.err}, 32'h1);
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    load(0, k128, 4, 0, 1'b0);
    wait_done("pre_zeroize", 40);
    bus.zeroize = 1'b1;
    cyc;
    bus.zeroize = 1'b0;
    chk("zeroize_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'h0);
    rd(0, 0, 32'h0, "zeroize_w0");
    rd(1, 0, 32'h0, "zeroize_w4");
    rd(10, 3, 32'h0, "zeroize_w43");
`endif
    load(1, k192, 6, 0, 1'b0);
    repeat (5) cyc;
    reset = 1'b0;
    cyc;
    chk("reset_mid_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'h0);
    chk("reset_mid_rd", bus.rd_data, 32'h0);
    reset = 1'b1;
    repeat (60) cyc;
    chk("reset_mid_stays_idle", {30'd0, bus.busy, bus.done}, 32'h0);
    repeat (2) cyc;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter MAX_NK, default 8; maximum supported key length in 32-bit words (legal values 4, 6, 8); sizes word storage to 4*(MAX_NK+7) words.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a new key load.
REQ-005 SHALL have port key_len  input  2  key size sampled with start: 0=128, 1=192, 2=256, 3=reserved.
REQ-006 SHALL have port key_word  input  32  cipher key word, most-significant word first.
REQ-007 SHALL have port key_valid  input  1  key_word is accepted on every LOAD cycle where this is high.
REQ-008 SHALL have port rd_round  input  4  round-key number to read.
REQ-009 SHALL have port rd_word  input  2  word within the round key; 0 selects bits [127:96].
REQ-010 SHALL have port rd_data  output  32  registered read data.
REQ-011 SHALL have ports busy  output  1 (high in LOAD/EXPAND), done  output  1 (schedule complete), err  output  1 (illegal key_len).

Function
REQ-012 SHALL set Nk = 4/6/8 for key_len 0/1/2, with Nr = Nk+6 and total words T = 4*(Nr+1) (44/52/60).
REQ-013 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE.
REQ-014 SHALL, on start in any state, latch key_len, clear done, err and the word counter, and go to LOAD; an in-flight load or expansion is abandoned.
REQ-015 SHALL treat start with key_len=3, or with Nk>MAX_NK, as illegal: err=1, state IDLE, busy=0, stored words unchanged.
REQ-016 SHALL, in LOAD, write each accepted key_word to w[i] in order i=0..Nk-1, and enter EXPAND on the edge that accepts word Nk-1.
REQ-017 SHALL ignore key_valid outside LOAD and in the cycle start is high.
REQ-018 SHALL, in EXPAND, generate exactly one word per cycle for i=Nk..T-1: temp=w[i-1]; if i mod Nk=0, temp=SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}; else if Nk=8 and i mod 8=4, temp=SubWord(temp); w[i]=w[i-Nk] xor temp.
REQ-019 SHALL use the FIPS-197 S-box (all 256 entries) and Rcon 01,02,04,08,10,20,40,80,1B,36.
REQ-020 SHALL write w[T-1] and assert done on the same edge, T-Nk cycles (40/46/52) after the edge that accepted the last key word; state then becomes DONE.
REQ-021 SHALL hold done=1 in DONE until the next start or reset.
REQ-022 SHALL register rd_data = w[4*rd_round+rd_word] with one-cycle latency in every state; index >= T of the latched mode SHALL return 0.

Reset
REQ-023 SHALL, while reset=0 at a rising edge, force state IDLE, rd_data=0, busy=0, done=0, err=0, and clear the counters; word storage need not be cleared.
REQ-024 SHALL give reset priority over start, and over zeroize when present.

Configuration
REQ-025 SHALL, when macro AES_KEY_SCHED_ZEROIZE_EN is defined, add input zeroize (1 bit): a high cycle clears all stored words to 0, clears done/err, aborts LOAD/EXPAND to IDLE, and takes priority over start.
REQ-026 SHALL, when AES_KEY_SCHED_ZEROIZE_EN is undefined, omit the zeroize port and all its logic.

Verification
REQ-027 SHALL cover AES-128: key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done 40 cycles after the last word; round 1 word 0 = a0fafe17; round 10 word 3 = b6630ca6.
REQ-028 SHALL cover AES-192: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w[6]=fe0c91f7, w[51] (round 12 word 3) = 01002202, done after 46 cycles.
REQ-029 SHALL cover AES-256: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411, w[59]=706c631e, done after 52 cycles.
REQ-030 SHALL cover key_valid gaps during LOAD (idle cycles between words) -> identical results to REQ-027; start in mid-EXPAND with a new key -> done only for the new key, correct words.
REQ-031 SHALL cover start with key_len=3, and key_len=2 with MAX_NK=4 -> err=1, busy=0, done=0; reads of rounds 11..15 in AES-128 mode -> 0.
REQ-032 SHALL cover, with AES_KEY_SCHED_ZEROIZE_EN defined, zeroize after done -> done=0 and all reads return 00000000; reset=0 mid-EXPAND -> IDLE, busy=0, done=0.
